// File: rtl/mac_rx.sv
// mac_rx: RMII receive MAC with destination filter, ethertype and payload word capture.
// Optional FCS check is enabled by defining MAC_RX_CRC_CHECK_EN, which adds the crc_err output.
module mac_rx #(
    parameter logic [47:0] MY_MAC     = 48'h69_69_69_69_69_69,
    parameter int          MAX_DIBITS = 6072
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crsdv,
    input  logic [1:0]  rxd,
    output logic [15:0] data,
    output logic [15:0] ethertype,
`ifdef MAC_RX_CRC_CHECK_EN
    output logic        crc_err,
`endif
    output logic        valid
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DROP, DONE} state_t;

    // MY_MAC rearranged into wire order so dibit i of the dst field sits at bits [2i+1:2i]
    localparam logic [63:0] MAC_WIRE = {16'h0, MY_MAC[7:0], MY_MAC[15:8], MY_MAC[23:16],
                                        MY_MAC[31:24], MY_MAC[39:32], MY_MAC[47:40]};

    state_t      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        uc_q, uc_d, bc_q, bc_d;
    logic [15:0] eth_q, eth_d, pay_q, pay_d;
    logic [15:0] data_q, data_d, ethertype_q, ethertype_d;
    logic        valid_q, valid_d;

`ifdef MAC_RX_CRC_CHECK_EN
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    logic [31:0] crc_q, crc_d;
    logic        crc_ok_q, crc_ok_d, crc_err_q, crc_err_d;

    // Reflected CRC-32 advanced by one dibit, rxd[0] first as it is earlier on the wire
    function automatic logic [31:0] crc2(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign crc_err = crc_err_q;
`endif

    assign data      = data_q;
    assign ethertype = ethertype_q;
    assign valid     = valid_q;

    // Next-state: preamble hunt, dibit capture with on-the-fly dst filter, end-of-frame verdict
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        uc_d        = uc_q;
        bc_d        = bc_q;
        eth_d       = eth_q;
        pay_d       = pay_q;
        data_d      = data_q;
        ethertype_d = ethertype_q;
        valid_d     = 1'b0;
`ifdef MAC_RX_CRC_CHECK_EN
        crc_d       = crc_q;
        crc_ok_d    = crc_ok_q;
        crc_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: state_d = (crsdv && rxd == 2'b01) ? PREAMBLE : IDLE;
            PREAMBLE: begin
                if (!crsdv) state_d = IDLE;
                else if (rxd == 2'b10) state_d = DROP;
                else if (rxd == 2'b11) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    uc_d    = 1'b1;
                    bc_d    = 1'b1;
`ifdef MAC_RX_CRC_CHECK_EN
                    crc_d   = '1;
`endif
                end
            end
            DATA: begin
                if (!crsdv) begin
                    state_d = (cnt_q[1:0] == 2'b00 && cnt_q >= 13'd256) ? DONE : IDLE;
`ifdef MAC_RX_CRC_CHECK_EN
                    crc_ok_d = (crc_q == CRC_RESIDUE);
`endif
                end else if (cnt_q == 13'(MAX_DIBITS)) begin
                    state_d = DROP;
                end else begin
                    cnt_d  = cnt_q + 13'd1;
                    byte_d = {rxd, byte_q[7:2]};
`ifdef MAC_RX_CRC_CHECK_EN
                    crc_d  = crc2(crc_q, rxd);
`endif
                    if (cnt_q < 13'd24) begin
                        uc_d = uc_q && (rxd == MAC_WIRE[{cnt_q[4:0], 1'b0} +: 2]);
                        bc_d = bc_q && (rxd == 2'b11);
                    end
                    if (cnt_q == 13'd23 && !(uc_d || bc_d)) state_d = DROP;
                    if (cnt_q[1:0] == 2'b11 && cnt_q[12:3] == 10'd6) eth_d = {eth_q[7:0], byte_d};
                    if (cnt_q[1:0] == 2'b11 && cnt_q[12:3] == 10'd7) pay_d = {pay_q[7:0], byte_d};
                end
            end
            DROP: state_d = crsdv ? DROP : IDLE;
            DONE: begin
                state_d = IDLE;
`ifdef MAC_RX_CRC_CHECK_EN
                valid_d     = crc_ok_q;
                crc_err_d   = !crc_ok_q;
                data_d      = crc_ok_q ? pay_q : data_q;
                ethertype_d = crc_ok_q ? eth_q : ethertype_q;
`else
                valid_d     = 1'b1;
                data_d      = pay_q;
                ethertype_d = eth_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            byte_q      <= '0;
            uc_q        <= 1'b0;
            bc_q        <= 1'b0;
            eth_q       <= '0;
            pay_q       <= '0;
            data_q      <= '0;
            ethertype_q <= '0;
            valid_q     <= 1'b0;
`ifdef MAC_RX_CRC_CHECK_EN
            crc_q       <= '1;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            uc_q        <= uc_d;
            bc_q        <= bc_d;
            eth_q       <= eth_d;
            pay_q       <= pay_d;
            data_q      <= data_d;
            ethertype_q <= ethertype_d;
            valid_q     <= valid_d;
`ifdef MAC_RX_CRC_CHECK_EN
            crc_q       <= crc_d;
            crc_ok_q    <= crc_ok_d;
            crc_err_q   <= crc_err_d;
`endif
        end
    end

endmodule
